// File: rtl/gearbox_tx_lanes.sv
// Multi-lane TX gearbox between the PCS scrambler and the PMA.
// Each lane packs (HEAD_W+DATA_W)-bit blocks {data, head} (head in the LSBs)
// into DATA_W-bit words, LSB first, with no bit dropped or duplicated.
// All lanes run in lockstep from one shared sequence counter.
//
// Ports:
//   clk         clock
//   nreset      synchronous active-low reset
//   data_v_i    input block valid, common to all lanes
//   head_i      sync headers, lane l at [l*HEAD_W +: HEAD_W]
//   data_i      payloads, lane l at [l*DATA_W +: DATA_W]
//   accept_v_o  block is taken this cycle if data_v_i=1 (low on flush cycles)
//   data_v_o    data_o holds a new word (registered)
//   data_o      output words, lane l at [l*DATA_W +: DATA_W] (registered)
//   seq_o       current gearbox sequence, 0..SHIFT_N
module gearbox_tx_lanes #(
  parameter int unsigned LANE_N = 4,
  parameter int unsigned DATA_W = 64,
  parameter int unsigned HEAD_W = 2,
  localparam int unsigned SHIFT_N = DATA_W / HEAD_W,
  localparam int unsigned SEQ_W = $clog2(SHIFT_N + 1)
) (
  input  logic                     clk,
  input  logic                     nreset,
  input  logic                     data_v_i,
  input  logic [LANE_N*HEAD_W-1:0] head_i,
  input  logic [LANE_N*DATA_W-1:0] data_i,
  output logic                     accept_v_o,
  output logic                     data_v_o,
  output logic [LANE_N*DATA_W-1:0] data_o,
  output logic [SEQ_W-1:0]         seq_o
);

  localparam int unsigned BLK_W = DATA_W + HEAD_W;
  localparam logic [SEQ_W-1:0] SEQ_MAX = SEQ_W'(SHIFT_N);

  logic [SEQ_W-1:0]         seq_q;
  logic [DATA_W-1:0]        res_q  [LANE_N];
  logic [DATA_W-1:0]        word_d [LANE_N];
  logic [DATA_W-1:0]        res_d  [LANE_N];
  logic [LANE_N*DATA_W-1:0] data_q;
  logic                     data_v_q;

  logic [BLK_W-1:0]  blk;
  logic [DATA_W-1:0] res_mask;
  int unsigned       lo_bits;

  assign accept_v_o = (seq_q != SEQ_MAX);
  assign seq_o      = seq_q;
  assign data_o     = data_q;
  assign data_v_o   = data_v_q;

  // With seq_q=s the residual holds s*HEAD_W valid bits. The new block is
  // placed just above them; whatever of the block does not fit in the word
  // (its top (s+1)*HEAD_W bits) becomes the next residual, right-aligned.
  always_comb begin
    lo_bits  = 32'(seq_q) * HEAD_W;
    res_mask = ~({DATA_W{1'b1}} << lo_bits);
    blk      = '0;
    for (int l = 0; l < LANE_N; l++) begin
      blk       = {data_i[l*DATA_W +: DATA_W], head_i[l*HEAD_W +: HEAD_W]};
      word_d[l] = DATA_W'(blk << lo_bits) | (res_q[l] & res_mask);
      res_d[l]  = DATA_W'(blk >> (DATA_W - lo_bits));
    end
  end

  always_ff @(posedge clk) begin
    if (!nreset) begin
      seq_q    <= '0;
      data_q   <= '0;
      data_v_q <= 1'b0;
      for (int l = 0; l < LANE_N; l++) begin
        res_q[l] <= '0;
      end
    end else if (seq_q == SEQ_MAX) begin
      // Residual is a full word: emit it and ignore the inputs this cycle.
      seq_q    <= '0;
      data_v_q <= 1'b1;
      for (int l = 0; l < LANE_N; l++) begin
        data_q[l*DATA_W +: DATA_W] <= res_q[l];
      end
    end else if (data_v_i) begin
      seq_q    <= seq_q + SEQ_W'(1);
      data_v_q <= 1'b1;
      for (int l = 0; l < LANE_N; l++) begin
        data_q[l*DATA_W +: DATA_W] <= word_d[l];
        res_q[l]                   <= res_d[l];
      end
    end else begin
      // Bubble: state and data_o hold.
      data_v_q <= 1'b0;
    end
  end

endmodule

// File: tb/tb_gearbox_tx_lanes.sv
// Self-checking bench for gearbox_tx_lanes (LANE_N=2, DATA_W=64, HEAD_W=2).
// The reference model keeps each lane's stream as a bit buffer: accepted
// blocks are appended LSB first and every emitted word is the oldest DATA_W
// bits. A flush is due whenever a full word of bits is already buffered.
module tb_gearbox_tx_lanes;

  localparam int unsigned LANE_N  = 2;
  localparam int unsigned DATA_W  = 64;
  localparam int unsigned HEAD_W  = 2;
  localparam int unsigned SHIFT_N = DATA_W / HEAD_W;
  localparam int unsigned SEQ_W   = $clog2(SHIFT_N + 1);
  localparam int unsigned FLAT_W  = LANE_N * DATA_W;
  localparam int unsigned SBUF_W  = 3 * DATA_W;

  localparam logic [DATA_W-1:0] BASE  = 64'h0123_4567_89AB_CDEF;
  localparam logic [DATA_W-1:0] LMASK = 64'hFFFF_0000_FFFF_0000;

  logic                     clk = 1'b0;
  logic                     nreset = 1'b0;
  logic                     data_v_i = 1'b0;
  logic [LANE_N*HEAD_W-1:0] head_i = '0;
  logic [LANE_N*DATA_W-1:0] data_i = '0;
  logic                     accept_v_o;
  logic                     data_v_o;
  logic [LANE_N*DATA_W-1:0] data_o;
  logic [SEQ_W-1:0]         seq_o;

  gearbox_tx_lanes #(
    .LANE_N(LANE_N),
    .DATA_W(DATA_W),
    .HEAD_W(HEAD_W)
  ) dut (
    .clk       (clk),
    .nreset    (nreset),
    .data_v_i  (data_v_i),
    .head_i    (head_i),
    .data_i    (data_i),
    .accept_v_o(accept_v_o),
    .data_v_o  (data_v_o),
    .data_o    (data_o),
    .seq_o     (seq_o)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string name, input logic [FLAT_W-1:0] act,
                     input logic [FLAT_W-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  // ---------------- reference model + per-cycle compare ----------------
  logic [SBUF_W-1:0]       sbuf [LANE_N];
  int unsigned             scnt = 0;
  logic                    exp_v = 1'b0;
  logic [FLAT_W-1:0]       exp_word = '0;
  logic [DATA_W+HEAD_W-1:0] mblk;
  bit                      model_live = 1'b0;

  always @(negedge clk) begin
    if (model_live) begin
      chk("accept", FLAT_W'(accept_v_o), FLAT_W'(scnt < DATA_W));
      chk("seq", FLAT_W'(seq_o), FLAT_W'(scnt / HEAD_W));
      chk("valid", FLAT_W'(data_v_o), FLAT_W'(exp_v));
      chk("data", data_o, exp_word);
    end
    if (!nreset) begin
      scnt     = 0;
      exp_v    = 1'b0;
      exp_word = '0;
      for (int l = 0; l < LANE_N; l++) sbuf[l] = '0;
      model_live = 1'b1;
    end else if (model_live) begin
      if (scnt >= DATA_W || data_v_i) begin
        if (scnt < DATA_W) begin
          for (int l = 0; l < LANE_N; l++) begin
            mblk    = {data_i[l*DATA_W +: DATA_W], head_i[l*HEAD_W +: HEAD_W]};
            sbuf[l] = sbuf[l] | (SBUF_W'(mblk) << scnt);
          end
          scnt = scnt + DATA_W + HEAD_W;
        end
        for (int l = 0; l < LANE_N; l++) begin
          exp_word[l*DATA_W +: DATA_W] = sbuf[l][DATA_W-1:0];
          sbuf[l] = sbuf[l] >> DATA_W;
        end
        scnt  = scnt - DATA_W;
        exp_v = 1'b1;
      end else begin
        exp_v = 1'b0;
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [DATA_W-1:0] d0, input logic [DATA_W-1:0] d1,
                       input logic [HEAD_W-1:0] h0, input logic [HEAD_W-1:0] h1);
    data_v_i = v;
    data_i   = {d1, d0};
    head_i   = {h1, h0};
    step();
  endtask

  function automatic logic [DATA_W-1:0] rnd64();
    return {$urandom, $urandom};
  endfunction

  logic [FLAT_W-1:0] saved;
  logic [DATA_W-1:0] d;
  int                nv;

  initial begin
    // Reset state.
    nreset = 1'b0;
    step();
    step();
    chk("rst_valid", FLAT_W'(data_v_o), '0);
    chk("rst_data", data_o, '0);
    chk("rst_seq", FLAT_W'(seq_o), '0);
    chk("rst_accept", FLAT_W'(accept_v_o), FLAT_W'(1));
    nreset = 1'b1;

    // Continuous valid: 32 blocks then the flush with data_v_i still high.
    nv = 0;
    for (int i = 0; i < 32; i++) begin
      d = BASE + DATA_W'(i);
      drive(1'b1, d, d ^ LMASK, 2'b01, 2'b01);
      if (data_v_o) nv++;
      if (i == 0) chk("t2_word0", FLAT_W'(data_o[DATA_W-1:0]), FLAT_W'(64'h048D_159E_26AF_37BD));
      if (i == 1) chk("t2_word1", FLAT_W'(data_o[DATA_W-1:0]), FLAT_W'(64'h1234_5678_9ABC_DF04));
    end
    chk("t2_seq_full", FLAT_W'(seq_o), FLAT_W'(32));
    chk("t2_accept_low", FLAT_W'(accept_v_o), '0);
    drive(1'b1, 64'hDEAD_BEEF_DEAD_BEEF, 64'hCAFE_F00D_CAFE_F00D, 2'b11, 2'b11);
    if (data_v_o) nv++;
    chk("t2_words", FLAT_W'(nv), FLAT_W'(33));
    chk("t4_flush_word", FLAT_W'(data_o[DATA_W-1:0]), FLAT_W'(64'h0123_4567_89AB_CE0E));
    chk("t4_seq_wrap", FLAT_W'(seq_o), '0);

    // Bubble at seq 5.
    for (int i = 0; i < 5; i++) drive(1'b1, rnd64(), rnd64(), 2'b10, 2'b01);
    chk("t3_seq5", FLAT_W'(seq_o), FLAT_W'(5));
    saved = data_o;
    for (int i = 0; i < 3; i++) begin
      drive(1'b0, rnd64(), rnd64(), 2'b11, 2'b00);
      chk("t3_bub_seq", FLAT_W'(seq_o), FLAT_W'(5));
      chk("t3_bub_valid", FLAT_W'(data_v_o), '0);
      chk("t3_bub_hold", data_o, saved);
    end
    for (int i = 0; i < 12; i++) drive(1'b1, rnd64(), rnd64(), 2'b01, 2'b10);
    chk("t5_seq17", FLAT_W'(seq_o), FLAT_W'(17));

    // Reset mid-period discards the residual.
    nreset = 1'b0;
    drive(1'b1, rnd64(), rnd64(), 2'b01, 2'b01);
    chk("t5_rst_seq", FLAT_W'(seq_o), '0);
    chk("t5_rst_valid", FLAT_W'(data_v_o), '0);
    nreset = 1'b1;
    drive(1'b1, '1, '1, 2'b10, 2'b10);
    chk("t5_first_word", FLAT_W'(data_o[DATA_W-1:0]), FLAT_W'(64'hFFFF_FFFF_FFFF_FFFE));
    chk("t5_first_valid", FLAT_W'(data_v_o), FLAT_W'(1));

    // Random traffic, independent data per lane, a mix of bubbles and bursts.
    for (int i = 0; i < 3000; i++) begin
      drive(($urandom_range(0, 3) != 0) || (i >= 2000 && i < 2200), rnd64(), rnd64(),
            2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)));
    end

    data_v_i = 1'b0;
    for (int i = 0; i < 4; i++) step();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
